// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state type, constants and helpers for the instruction loader
package loader_pkg;

  // Loader control states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD    = 4;
  localparam int          BYTE_W            = 8;
  localparam int          WORD_W            = BYTES_PER_WORD * BYTE_W;

  // Number of bits needed to hold values 0 .. value-1
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - big-endian byte-to-word shifter with inter-byte timeout
module word_assembler
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic              i_count_en,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_done,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  output logic              o_timeout
);

  localparam int IDX_W   = (clog2(BYTES_PER_WORD) < 1) ? 1 : clog2(BYTES_PER_WORD);
  localparam int TIMER_W = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [WORD_W-1:0]  shift_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TIMER_W-1:0] timer_q;
  logic               byte_take;

  assign byte_take    = i_accept & i_rx_done;
  // Word as it looks once the byte on the bus is shifted in; the top latches
  // this on the fourth byte so the write can go out the very next cycle.
  assign o_word       = {shift_q[WORD_W-BYTE_W-1:0], i_rx_data};
  assign o_word_valid = byte_take && (idx_q == LAST_IDX);
  // A byte arriving in the same cycle beats the timeout.
  assign o_timeout    = i_count_en && (idx_q != '0) && !i_rx_done && (timer_q == TIMER_MAX);

  // Shift register, byte index and gap timer; timer only runs mid-word
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      shift_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else if (byte_take) begin
      shift_q <= o_word;
      idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      timer_q <= '0;
    end else if (i_count_en && (idx_q != '0) && (timer_q != TIMER_MAX)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_instruction_loader.sv
// rtl/mem_instruction_loader.sv - UART byte stream to instruction memory bootloader
module mem_instruction_loader
  import loader_pkg::*;
#(
  parameter int          RAM_WIDTH      = 32,
  parameter int          RAM_DEPTH      = 2048,
  parameter logic [31:0] HALT_WORD      = HALT_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  output logic [RAM_WIDTH-1:0] o_addr,
  output logic [RAM_WIDTH-1:0] o_dina,
  output logic                 o_wea,
  output logic                 o_ena,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [RAM_WIDTH-1:0] o_word_count
);

  localparam int ADDR_W = (clog2(RAM_DEPTH) < 1) ? 1 : clog2(RAM_DEPTH);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [RAM_WIDTH-1:0] COUNT_MAX = RAM_WIDTH'(RAM_DEPTH);

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]  word_q;
  logic               asm_clear;
  logic               asm_accept;
  logic               asm_count_en;
  logic [WORD_W-1:0]  asm_word;
  logic               asm_word_valid;
  logic               asm_timeout;

  // Bytes are taken in WRITE too, so a strobe during the write cycle
  // becomes byte 0 of the following word.
  assign asm_accept   = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign asm_count_en = (state_q == ST_RECV);

  word_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_word_assembler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (asm_clear),
    .i_accept    (asm_accept),
    .i_count_en  (asm_count_en),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_word      (asm_word),
    .o_word_valid(asm_word_valid),
    .o_timeout   (asm_timeout)
  );

  // Next-state logic; start is honoured only outside RECV/WRITE
  always_comb begin
    state_d   = state_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d   = ST_RECV;
          asm_clear = 1'b1;
        end
      end
      ST_RECV: begin
        if (asm_word_valid) begin
          state_d = ST_WRITE;
        end else if (asm_timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        if (word_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address/count registers and registered outputs decoded from next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      word_q       <= '0;
      o_addr       <= '0;
      o_dina       <= '0;
      o_wea        <= 1'b0;
      o_ena        <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_word_count <= '0;
    end else begin
      state_q <= state_d;
      o_wea   <= (state_d == ST_WRITE);
      o_ena   <= (state_d == ST_WRITE);
      o_busy  <= (state_d == ST_RECV) || (state_d == ST_WRITE);
      o_done  <= (state_d == ST_DONE);
      o_error <= (state_d == ST_ERROR);

      if (state_d == ST_WRITE) begin
        word_q <= asm_word;
        o_addr <= RAM_WIDTH'(addr_q);
        o_dina <= RAM_WIDTH'(asm_word);
      end else begin
        o_addr <= '0;
        o_dina <= '0;
      end

      if (asm_clear) begin
        addr_q       <= '0;
        o_word_count <= '0;
      end else if (state_q == ST_WRITE) begin
        addr_q <= addr_q + 1'b1;
        if (o_word_count != COUNT_MAX) begin
          o_word_count <= o_word_count + RAM_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_instruction_loader.sv
// tb/tb_mem_instruction_loader.sv - self-checking bench for mem_instruction_loader
module tb_mem_instruction_loader;

  localparam int          RAM_WIDTH      = 32;
  localparam int          RAM_DEPTH      = 4;
  localparam int          TIMEOUT_CYCLES = 16;
  localparam logic [31:0] HALT           = 32'hFFFF_FFFF;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 i_start = 1'b0;
  logic [7:0]           i_rx_data = 8'h00;
  logic                 i_rx_done = 1'b0;
  logic [RAM_WIDTH-1:0] o_addr;
  logic [RAM_WIDTH-1:0] o_dina;
  logic                 o_wea;
  logic                 o_ena;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;
  logic [RAM_WIDTH-1:0] o_word_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_done;
  logic        exp_error;
  logic        prev_wea = 1'b0;

  mem_instruction_loader #(
    .RAM_WIDTH     (RAM_WIDTH),
    .RAM_DEPTH     (RAM_DEPTH),
    .HALT_WORD     (HALT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_addr      (o_addr),
    .o_dina      (o_dina),
    .o_wea       (o_wea),
    .o_ena       (o_ena),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // Capture every memory write; each pulse must be single-cycle with ena
  always @(negedge i_clk) begin
    if (o_wea === 1'b1) begin
      wr_addr_q.push_back(o_addr);
      wr_data_q.push_back(o_dina);
      checks++;
      assert (o_ena === 1'b1 && prev_wea === 1'b0)
      else begin
        errors++;
        $error("FAIL wea_pulse: observed ena=%b prev_wea=%b expected ena=1 prev_wea=0", o_ena, prev_wea);
      end
    end
    prev_wea = o_wea;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_addr", tag), o_addr, 32'h0);
    check($sformatf("%s_dina", tag), o_dina, 32'h0);
    check($sformatf("%s_wea", tag), 32'(o_wea), 32'h0);
    check($sformatf("%s_ena", tag), 32'(o_ena), 32'h0);
    check($sformatf("%s_busy", tag), 32'(o_busy), 32'h0);
    check($sformatf("%s_done", tag), 32'(o_done), 32'h0);
    check($sformatf("%s_error", tag), 32'(o_error), 32'h0);
    check($sformatf("%s_count", tag), o_word_count, 32'h0);
  endtask

  // Reference: words land at 0,1,2,... until HALT is written or the last address is used
  task automatic model();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    for (int i = 0; i < prog.size() && !exp_done && !exp_error; i++) begin
      exp_addr_q.push_back(32'(i));
      exp_data_q.push_back(prog[i]);
      if (prog[i] == HALT) exp_done = 1'b1;
      else if (i == RAM_DEPTH - 1) exp_error = 1'b1;
    end
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(o_done === 1'b1 || o_error === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check($sformatf("%s_finished", tag), 32'(o_done | o_error), 32'h1);
    repeat (3) tick();
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s_nwrites", tag), 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    check($sformatf("%s_done", tag), 32'(o_done), 32'(exp_done));
    check($sformatf("%s_error", tag), 32'(o_error), 32'(exp_error));
    check($sformatf("%s_count", tag), o_word_count, 32'(exp_addr_q.size()));
    check($sformatf("%s_idle_busy", tag), 32'(o_busy), 32'h0);
  endtask

  task automatic begin_load(input string tag);
    model();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    check($sformatf("%s_busy_rise", tag), 32'(o_busy), 32'h1);
    check($sformatf("%s_done_clr", tag), 32'(o_done), 32'h0);
    check($sformatf("%s_error_clr", tag), 32'(o_error), 32'h0);
  endtask

  task automatic run_load(input string tag, input bit rnd);
    begin_load(tag);
    for (int i = 0; i < prog.size(); i++) send_word(prog[i], rnd);
    wait_end(tag);
    compare(tag);
  endtask

  initial begin
    logic [31:0] w;
    int n;

    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    check_all_zero("reset");

    // Basic load with zero gaps: every next byte 0 arrives during the WRITE cycle
    prog = '{32'h0011_2233, 32'h8C01_0004, HALT};
    run_load("basic_b2b", 1'b0);

    // Restart from DONE with a single HALT word
    prog = '{HALT};
    run_load("restart_done", 1'b0);

    // Overflow: four non-HALT words fill the memory
    prog = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    run_load("overflow", 1'b0);

    // HALT as the last fitting word wins over overflow
    prog = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, HALT};
    run_load("halt_at_last", 1'b1);

    // Timeout: one full word, then two bytes and a stall
    prog = '{32'hCAFE_F00D};
    begin_load("timeout");
    send_word(32'hCAFE_F00D, 1'b0);
    repeat (3) tick();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("timeout_early", 32'(o_error), 32'h0);
    tick();
    check("timeout_fire", 32'(o_error), 32'h1);
    exp_error = 1'b1;
    repeat (3) tick();
    compare("timeout");

    // Start pulse mid-word is ignored
    prog = '{32'hDEAD_BEEF, HALT};
    begin_load("start_in_recv");
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 1);
    pulse_start();
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_word(HALT, 1'b0);
    wait_end("start_in_recv");
    compare("start_in_recv");

    // Reset mid-word returns everything to zero, then a clean HALT load
    prog = '{32'h0102_0304};
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_all_zero("mid_reset");
    // Bytes while idle must be ignored
    send_word(32'h0A0B_0C0D, 1'b0);
    tick();
    check_all_zero("idle_bytes");
    prog = '{HALT};
    run_load("after_reset", 1'b0);

    // Randomized programs with random inter-byte gaps
    for (int t = 0; t < 20; t++) begin
      prog.delete();
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        prog.push_back(w);
      end
      if ($urandom_range(0, 1) == 1) prog[n-1] = HALT;
      if (prog.size() < RAM_DEPTH && prog[prog.size()-1] != HALT) prog.push_back(HALT);
      run_load($sformatf("rand%0d", t), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_instruction_loader.md
# mem_instruction_loader

Bootloader that fills the instruction memory before the MIPS pipeline runs. It takes a byte stream from the UART receiver, assembles big-endian 32-bit words and drives the instruction memory's write port at consecutive word addresses. Loading stops when the HALT word has been written. It reports done or error to the debug unit, which then releases the pipeline.

## Interface
Parameters:
- RAM_WIDTH, 32, data and address width; matches the instruction memory.
- RAM_DEPTH, 2048, number of instruction words; the highest valid address is RAM_DEPTH-1.
- HALT_WORD, 32'hFFFF_FFFF, encoding that ends a program load.
- TIMEOUT_CYCLES, 100000, maximum gap in cycles between bytes of one word.

Ports (one clock, i_clk; reset i_rst is synchronous and active-high):
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse that begins a load.
- i_rx_data  in  8  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle byte strobe from the UART receiver.
- o_addr  out  RAM_WIDTH  word address to the memory's i_addr.
- o_dina  out  RAM_WIDTH  write data to the memory's i_dina.
- o_wea  out  1  write enable.
- o_ena  out  1  RAM enable.
- o_busy  out  1  high while in RECV or WRITE.
- o_done  out  1  load completed; sticky.
- o_error  out  1  timeout or overflow; sticky.
- o_word_count  out  RAM_WIDTH  number of words written, including the HALT word.

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - All outputs are 0.
  - i_start: clear the address, byte index, timer and word count, then go to RECV.
- RECV:
  - On i_rx_done: word <= {word[23:0], i_rx_data}; byte index +1.
  - Fourth byte (index 3) → WRITE; the byte index wraps to 0.
- WRITE (exactly one cycle):
  - Drives o_ena=1, o_wea=1, o_addr=addr, o_dina=word.
  - Next cycle: addr+1, o_word_count+1.
  - word==HALT_WORD → DONE. This check takes priority over overflow.
  - Otherwise, if addr==RAM_DEPTH-1 → ERROR (overflow: no room left for HALT).
  - Otherwise → RECV.
- A strobe arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
- Timeout:
  - The timer counts only in RECV while the byte index ≠ 0.
  - It clears on every i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1 → ERROR; the partial word is discarded and never written.
- DONE / ERROR:
  - o_done / o_error held at 1, o_ena=o_wea=0.
  - Strobes are ignored.
  - i_start restarts the load exactly as from IDLE and clears the flag.
- i_start in RECV or WRITE is ignored.
- i_rst at any time:
  - Go to IDLE and zero all registers and outputs.
  - A write already performed stays in memory; no further write is issued.

## Timing
- Reset values: o_addr=0, o_dina=0, o_wea=0, o_ena=0, o_busy=0, o_done=0, o_error=0, o_word_count=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: the write pulse is asserted in the cycle after the cycle in which the 4th strobe is sampled.
- o_wea and o_ena are never high for more than 1 consecutive cycle.
- o_busy rises the cycle after i_start.
- o_done / o_error rise the cycle after the final WRITE or the timeout.
- Address width: the internal address counter is clog2(RAM_DEPTH) bits, zero-extended onto o_addr.
- o_word_count saturates at RAM_DEPTH.

## Structure
- The shared package `loader_pkg` holds:
  - the state enum;
  - the HALT_WORD default;
  - the BYTES_PER_WORD=4 constant;
  - a clog2 function.
- Natural sub-module: `word_assembler`, covering the shift register, byte index and timeout timer. Its outputs are o_word, o_word_valid and o_timeout. The FSM stays in the top module.

## Test plan
- Basic load: start, then bytes 00 11 22 33, 8C 01 00 04, FF FF FF FF.
  - Writes 0x00112233@0, 0x8C010004@1, 0xFFFFFFFF@2, one cycle each.
  - Then o_done=1 and o_word_count=3.
- Back-to-back: a strobe in the WRITE cycle is accepted as byte 0 of the next word.
  - The next word is assembled correctly; no byte is lost.
- Timeout: TIMEOUT_CYCLES=16, send 2 bytes then stall 16 cycles.
  - o_error=1, no write pulse, o_word_count unchanged.
- Overflow: RAM_DEPTH=4, send 4 non-HALT words.
  - Writes @0..3, then o_error=1.
  - HALT as the 4th word instead gives o_done=1.
- Reset mid-word: after 3 bytes, pulse i_rst.
  - All outputs return to 0.
  - A following start plus a HALT word writes 0xFFFFFFFF@0.
- Restart from DONE: pulse i_start, then load 1 HALT word.
  - o_done drops then re-rises, o_word_count=1, the write goes to addr 0.
